// File: rtl/key_pkg.sv
// Shared constants and event bundle for the push-button debounce
// and event scheduler.
package key_pkg;

    localparam int   DEF_N_KEYS       = 4;
    localparam int   DEF_TICK_DIV     = 50000;
    localparam int   DEF_STABLE_TICKS = 10;
    localparam logic DEF_RST_LEVEL    = 1'b1;

    // Wide enough for the largest supported key count (16)
    localparam int KEY_IDX_W = 4;

    typedef struct packed {
        logic [KEY_IDX_W-1:0] idx;
        logic                 lvl;
    } key_ev_t;

endpackage

// File: rtl/key_event_arb_if.sv
// Key inputs, debounced levels, overrun flags and the valid/ready
// event port of the key event arbiter.
interface key_event_arb_if #(
    parameter int N_KEYS = 4
);
    localparam int IW = $clog2(N_KEYS);

    logic [N_KEYS-1:0] keyin;
    logic [N_KEYS-1:0] key_state;
    logic              ev_valid;
    logic              ev_ready;
    logic [IW-1:0]     ev_key;
    logic              ev_level;
    logic [N_KEYS-1:0] overrun;
    logic              ovr_clr;

    modport master (
        input  keyin,
        input  ev_ready,
        input  ovr_clr,
        output key_state,
        output ev_valid,
        output ev_key,
        output ev_level,
        output overrun
    );

    modport slave (
        output keyin,
        output ev_ready,
        output ovr_clr,
        input  key_state,
        input  ev_valid,
        input  ev_key,
        input  ev_level,
        input  overrun
    );

endinterface

// File: rtl/key_filter.sv
// One key: 2-flop synchroniser and tick-paced stability counter that
// accepts a new level after STABLE_TICKS consecutive mismatching ticks.
module key_filter
    import key_pkg::*;
#(
    parameter int   STABLE_TICKS = DEF_STABLE_TICKS,
    parameter logic RST_LEVEL    = DEF_RST_LEVEL
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic keyin,
    output logic key_state,
    output logic detect
);

    localparam int CW = $clog2(STABLE_TICKS) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic          sync1_q, sync2_q;
    logic          state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= RST_LEVEL;
            sync2_q <= RST_LEVEL;
            state_q <= RST_LEVEL;
            cnt_q   <= '0;
        end else begin
            sync1_q <= keyin;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        detect  = 1'b0;
        if (tick) begin
            if (sync2_q == state_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                state_d = sync2_q;
                cnt_d   = '0;
                detect  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign key_state = state_q;

endmodule

// File: rtl/key_event_arb.sv
// Shared sample-tick prescaler, per-key filters, pending/overrun latches
// and a round-robin arbiter feeding one valid/ready event port.
module key_event_arb
    import key_pkg::*;
#(
    parameter int   N_KEYS       = DEF_N_KEYS,
    parameter int   TICK_DIV     = DEF_TICK_DIV,
    parameter int   STABLE_TICKS = DEF_STABLE_TICKS,
    parameter logic RST_LEVEL    = DEF_RST_LEVEL
) (
    input logic            clk,
    input logic            rst,
    key_event_arb_if.master bus
);

    localparam int IW = $clog2(N_KEYS);
    localparam int DW = $clog2(TICK_DIV);

    logic [DW-1:0]     div_q, div_d;
    logic              tick;
    logic [N_KEYS-1:0] ks;
    logic [N_KEYS-1:0] det;
    logic [N_KEYS-1:0] pend_q, pend_d;
    logic [N_KEYS-1:0] lvl_q, lvl_d;
    logic [N_KEYS-1:0] ovr_q, ovr_d;
    logic [N_KEYS-1:0] gnt;
    logic [IW-1:0]     last_q, last_d;
    logic [IW-1:0]     gidx;
    logic              found;
    logic              load;
    logic              valid_q, valid_d;
    key_ev_t           ev_q, ev_d;
    int                sel;

    assign tick  = (div_q == DW'(TICK_DIV - 1));
    assign div_d = tick ? '0 : div_q + 1'b1;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_filter #(
            .STABLE_TICKS(STABLE_TICKS),
            .RST_LEVEL   (RST_LEVEL)
        ) u_flt (
            .clk      (clk),
            .rst      (rst),
            .tick     (tick),
            .keyin    (bus.keyin[i]),
            .key_state(ks[i]),
            .detect   (det[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            pend_q  <= '0;
            lvl_q   <= '0;
            ovr_q   <= '0;
            last_q  <= IW'(N_KEYS - 1);
            valid_q <= 1'b0;
            ev_q    <= '0;
        end else begin
            div_q   <= div_d;
            pend_q  <= pend_d;
            lvl_q   <= lvl_d;
            ovr_q   <= ovr_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            ev_q    <= ev_d;
        end
    end

    // Round-robin search starting just after the last granted key
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        sel   = 0;
        for (int k = 1; k <= N_KEYS; k++) begin
            sel = (int'(last_q) + k) % N_KEYS;
            if (!found && pend_q[sel]) begin
                found = 1'b1;
                gidx  = IW'(sel);
            end
        end
    end

    assign load = !valid_q || bus.ev_ready;

    always_comb begin
        gnt = '0;
        if (load && found) begin
            gnt[gidx] = 1'b1;
        end
    end

    always_comb begin
        valid_d = valid_q;
        ev_d    = ev_q;
        last_d  = last_q;
        if (load) begin
            valid_d = found;
            if (found) begin
                ev_d.idx = KEY_IDX_W'(gidx);
                ev_d.lvl = lvl_q[gidx];
                last_d   = gidx;
            end
        end
    end

    // A fresh detect beats a same-cycle grant; overrun only if the old event stays
    always_comb begin
        pend_d = pend_q & ~gnt;
        lvl_d  = lvl_q;
        ovr_d  = bus.ovr_clr ? '0 : ovr_q;
        for (int i = 0; i < N_KEYS; i++) begin
            if (det[i]) begin
                pend_d[i] = 1'b1;
                lvl_d[i]  = ~ks[i];
                if (pend_q[i] && !gnt[i]) begin
                    ovr_d[i] = 1'b1;
                end
            end
        end
    end

    assign bus.key_state = ks;
    assign bus.ev_valid  = valid_q;
    assign bus.ev_key    = IW'(ev_q.idx);
    assign bus.ev_level  = ev_q.lvl;
    assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_key_event_arb.sv
// Directed bench for key_event_arb: reset, press, bounce, round-robin
// ordering and overrun, with hand-computed expectations.
module tb_key_event_arb;

    localparam int NK = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        int key;
        int lvl;
        int cyc;
    } ev_rec_t;

    ev_rec_t evq[$];

    key_event_arb_if #(.N_KEYS(NK)) bus ();

    key_event_arb #(
        .N_KEYS      (NK),
        .TICK_DIV    (4),
        .STABLE_TICKS(3),
        .RST_LEVEL   (1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!rst && bus.ev_valid && bus.ev_ready) begin
            evq.push_back('{int'(bus.ev_key), int'(bus.ev_level), cyc});
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ks(input int k, input logic v, input string tag,
                           output int n);
        n = 0;
        while (bus.key_state[k] !== v && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk(tag, int'(bus.key_state[k]), int'(v));
    endtask

    function automatic int qkey(input int i);
        return (i < evq.size()) ? evq[i].key : -1;
    endfunction

    function automatic int qlvl(input int i);
        return (i < evq.size()) ? evq[i].lvl : -1;
    endfunction

    initial begin
        int n;
        bus.keyin    = 4'hF;
        bus.ev_ready = 1'b1;
        bus.ovr_clr  = 1'b0;
        step(3);
        rst = 1'b0;
        step(2);

        chk("rst_ks", int'(bus.key_state), 15);
        chk("rst_valid", int'(bus.ev_valid), 0);
        chk("rst_key", int'(bus.ev_key), 0);
        chk("rst_lvl", int'(bus.ev_level), 0);
        chk("rst_ovr", int'(bus.overrun), 0);
        step(20);
        chk("idle_noev", evq.size(), 0);

        // clean press on key 2
        evq.delete();
        bus.keyin[2] = 1'b0;
        wait_ks(2, 1'b0, "press_ks", n);
        chk("press_lat", int'(n <= 14), 1);
        step(3);
        chk("press_cnt", evq.size(), 1);
        chk("press_key", qkey(0), 2);
        chk("press_lvl", qlvl(0), 0);

        // bounce on key 1: 5-cycle pulses never span 3 ticks
        evq.delete();
        for (int i = 0; i < 8; i++) begin
            bus.keyin[1] = ~bus.keyin[1];
            step(5);
        end
        step(20);
        chk("bnc_noev", evq.size(), 0);
        chk("bnc_ks", int'(bus.key_state), 4'b1011);

        // release key 2
        bus.keyin[2] = 1'b1;
        wait_ks(2, 1'b1, "rel_ks", n);
        step(3);
        chk("rel_cnt", evq.size(), 1);
        chk("rel_key", qkey(0), 2);
        chk("rel_lvl", qlvl(0), 1);

        // reset mid-operation with events in flight
        evq.delete();
        bus.ev_ready = 1'b0;
        bus.keyin    = 4'b1010;
        wait_ks(0, 1'b0, "mid_ks0", n);
        step(2);
        chk("mid_valid_pre", int'(bus.ev_valid), 1);
        rst = 1'b1;
        bus.keyin = 4'hF;
        #1;
        chk("mid_ks", int'(bus.key_state), 15);
        chk("mid_valid", int'(bus.ev_valid), 0);
        chk("mid_key", int'(bus.ev_key), 0);
        chk("mid_ovr", int'(bus.overrun), 0);
        step(2);
        rst = 1'b0;
        bus.ev_ready = 1'b1;
        step(30);
        chk("mid_noev", evq.size(), 0);
        chk("mid_ks_post", int'(bus.key_state), 15);

        // keys 0, 1, 3 on the same tick, consumer stalled
        evq.delete();
        bus.ev_ready = 1'b0;
        bus.keyin    = 4'b0100;
        n = 0;
        while (!bus.ev_valid && n < 30) begin
            step(1);
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            chk("rr_hold_v", int'(bus.ev_valid), 1);
            chk("rr_hold_k", int'(bus.ev_key), 0);
            step(1);
        end
        bus.ev_ready = 1'b1;
        step(5);
        chk("rr_cnt", evq.size(), 3);
        chk("rr_k0", qkey(0), 0);
        chk("rr_k1", qkey(1), 1);
        chk("rr_k2", qkey(2), 3);
        chk("rr_l0", qlvl(0), 0);
        chk("rr_back2back",
            (evq.size() == 3) ? evq[2].cyc - evq[0].cyc : -1, 2);

        bus.keyin = 4'hF;
        wait_ks(0, 1'b1, "rr_rel", n);
        step(4);
        chk("rr_rel_cnt", evq.size(), 6);

        // overrun: key 1 holds the output, key 0 changes twice
        evq.delete();
        bus.ev_ready = 1'b0;
        bus.keyin[1] = 1'b0;
        wait_ks(1, 1'b0, "ovr_ks1", n);
        step(2);
        bus.keyin[0] = 1'b0;
        wait_ks(0, 1'b0, "ovr_ks0a", n);
        step(2);
        chk("ovr_none", int'(bus.overrun), 0);
        bus.keyin[0] = 1'b1;
        wait_ks(0, 1'b1, "ovr_ks0b", n);
        step(1);
        chk("ovr_set", int'(bus.overrun), 1);
        chk("ovr_hold_k", int'(bus.ev_key), 1);
        bus.ev_ready = 1'b1;
        step(4);
        chk("ovr_cnt", evq.size(), 2);
        chk("ovr_k0", qkey(0), 1);
        chk("ovr_l0", qlvl(0), 0);
        chk("ovr_k1", qkey(1), 0);
        chk("ovr_l1", qlvl(1), 1);
        chk("ovr_sticky", int'(bus.overrun), 1);
        bus.ovr_clr = 1'b1;
        step(1);
        bus.ovr_clr = 1'b0;
        chk("ovr_clr", int'(bus.overrun), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/key_event_arb.md
# key_event_arb

Multi-key debounce controller and event scheduler for the board's push-buttons. A single shared sample-tick prescaler paces N per-key stability filters. Every debounced level change is latched as a pending event. A round-robin arbiter serialises pending events onto one valid/ready event port, which feeds the display/control logic downstream of the keys.

## Interface
- `N_KEYS`, 4: number of raw key inputs (2..16).
- `TICK_DIV`, 50000: clk cycles per sample tick (1 ms at 50 MHz); ≥2.
- `STABLE_TICKS`, 10: consecutive mismatching ticks required to accept a new level; ≥1.
- `RST_LEVEL`, 1'b1: debounced level of every key after reset (pull-up buttons).
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `keyin`  in  N_KEYS  raw, asynchronous key levels.
- `key_state`  out  N_KEYS  current debounced levels.
- `ev_valid`  out  1  event available.
- `ev_ready`  in  1  consumer accepts event when high with ev_valid.
- `ev_key`  out  clog2(N_KEYS)  index of key that changed.
- `ev_level`  out  1  new debounced level of ev_key.
- `overrun`  out  N_KEYS  sticky: a key changed again while its previous event was still pending.
- `ovr_clr`  in  1  synchronous clear of all overrun bits.

## Operation
- Sync: each keyin bit passes through a 2-flop synchroniser; the filter uses only the second flop.
- Prescaler: `div_cnt` counts 0..TICK_DIV-1 and wraps. `tick` is high for one cycle when div_cnt==TICK_DIV-1.
- Per-key filter, evaluated only on tick:
  - sync==key_state: stab_cnt←0.
  - sync!=key_state and stab_cnt<STABLE_TICKS-1: stab_cnt+1.
  - sync!=key_state and stab_cnt==STABLE_TICKS-1: key_state←sync, stab_cnt←0, detect pulse.
  - stab_cnt width is clog2(STABLE_TICKS)+1. The counter never wraps.
- Pending: on detect, pend[i]←1 and pend_lvl[i]←new level. If pend[i] was already 1 and not granted in the same cycle, overrun[i]←1 and pend_lvl is overwritten with the latest level.
- Arbiter:
  - Output register loads when !ev_valid or (ev_valid && ev_ready).
  - It grants the first set pend bit searching from last_grant+1, wrapping modulo N_KEYS.
  - On a grant, in the same cycle: ev_valid←1, ev_key←i, ev_level←pend_lvl[i], pend[i]←0, last_grant←i.
  - No pending bit at a load opportunity: ev_valid←0.
- Simultaneous grant and detect on the same key: set wins. pend stays 1 with the new level and no overrun is flagged, because the old event left.
- ovr_clr and overrun-set in the same cycle: set wins.
- Handshake: ev_key and ev_level are held stable while ev_valid && !ev_ready. ev_valid never drops without acceptance.

## Timing
- Reset values (async): key_state=all RST_LEVEL; sync flops=RST_LEVEL. All of the following are 0: div_cnt, stab_cnt, pend, pend_lvl, ev_valid, ev_key, ev_level, overrun. last_grant=N_KEYS-1, so key 0 has first priority.
- keyin change to key_state change: 2 sync cycles plus between (STABLE_TICKS-1)·TICK_DIV+1 and STABLE_TICKS·TICK_DIV cycles.
- key_state change to ev_valid: 1 cycle if the output register is free. pend is set on the detect edge and the grant happens on the next edge.
- Throughput: one event per cycle with ev_ready held high.
- A bounce shorter than STABLE_TICKS ticks produces no event and no key_state change.

## Structure
- Shared package `key_pkg` holds:
  - the default TICK_DIV, STABLE_TICKS and RST_LEVEL constants;
  - `key_ev_t`, a struct of key index and level, sized by a package `KEY_IDX_W`.
- Sub-module `key_filter` contains the synchroniser, stab_cnt, key_state and detect pulse. It takes `tick` as an input and is instantiated N_KEYS times.
- The top level holds the prescaler, the pending/overrun registers and the round-robin arbiter.

## Test plan
Bench parameters: N_KEYS=4, TICK_DIV=4, STABLE_TICKS=3, ev_ready=1 unless stated.
- Reset mid-operation: assert rst with pend=4'b0101 and ev_valid=1. All outputs return to reset values immediately. key_state=4'b1111. No event after release.
- Clean press: keyin[2] goes 1→0 and holds. key_state[2]=0 within 2+12 cycles. Exactly one event: ev_key=2, ev_level=0.
- Bounce rejection: keyin[1] toggles every 5 cycles for 40 cycles, then returns to 1. No event, key_state[1] stays 1, stab_cnt returns to 0.
- Round-robin arbitration: keys 0, 1 and 3 change on the same tick, with ev_ready low for 3 cycles. ev_key=0 is held stable, then 1, then 3 on consecutive accepted cycles.
- Overrun: ev_ready=0 and key 0 pending. Release key 0 and let it debounce back to 1. overrun[0]=1 and pend_lvl[0]=1. After raising ev_ready, the single event has ev_level=1. ovr_clr clears overrun to 0.
